// File: rtl/complex_mult_master_if.sv
// complex_mult_master_if: host operand/result FIFO ports plus the operand and result handshakes to the multiplier.
interface complex_mult_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH = 16
);
  logic                    cmd_wr;
  logic [DATA_WIDTH-1:0]   cmd_1_re, cmd_1_im, cmd_2_re, cmd_2_im;
  logic                    cmd_full;
  logic                    ovf;
  logic                    op_val;
  logic                    op_ready;
  logic [DATA_WIDTH-1:0]   op_1_re, op_1_im, op_2_re, op_2_im;
  logic                    res_val;
  logic                    res_ready;
  logic [2*DATA_WIDTH-1:0] result_re, result_im;
  logic                    rd_en;
  logic [2*DATA_WIDTH-1:0] rd_re, rd_im;
  logic                    rd_empty;
  logic [CNT_WIDTH-1:0]    done_cnt;
  modport master (
    input  cmd_wr, cmd_1_re, cmd_1_im, cmd_2_re, cmd_2_im, op_ready, res_val, result_re, result_im, rd_en,
    output cmd_full, ovf, op_val, op_1_re, op_1_im, op_2_re, op_2_im, res_ready, rd_re, rd_im, rd_empty, done_cnt
  );
  modport slave (
    output cmd_wr, cmd_1_re, cmd_1_im, cmd_2_re, cmd_2_im, op_ready, res_val, result_re, result_im, rd_en,
    input  cmd_full, ovf, op_val, op_1_re, op_1_im, op_2_re, op_2_im, res_ready, rd_re, rd_im, rd_empty, done_cnt
  );
endinterface

// File: rtl/complex_mult_master.sv
// complex_mult_master: buffers host operand sets, issues them one at a time to a sequential complex multiplier
// and queues each result for the host; a new operation starts only when a result slot is guaranteed.
module complex_mult_master #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rstn,
  input logic sw_rst,
  complex_mult_master_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = 4 * DATA_WIDTH;
  localparam int RW = 4 * DATA_WIDTH;
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2;
  logic [OW-1:0] cmem [DEPTH];
  logic [RW-1:0] rmem [DEPTH];
  logic [AW-1:0] cwp_q, cwp_d, crp_q, crp_d, rwp_q, rwp_d, rrp_q, rrp_d;
  logic [AW:0] ccnt_q, ccnt_d, rcnt_q, rcnt_d;
  logic [1:0] st_q, st_d;
  logic [OW-1:0] op_q, op_d;
  logic ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic c_full, r_empty, c_push, c_pop, r_push, r_pop, start;
  assign c_full  = ccnt_q == (AW+1)'(DEPTH);
  assign r_empty = rcnt_q == '0;
  assign c_push  = bus.cmd_wr && !c_full;
  assign c_pop   = st_q == ISSUE && bus.op_ready;
  assign r_push  = st_q == WAIT && bus.res_val;
  assign r_pop   = bus.rd_en && !r_empty;
  // Start only with a free result slot so a returning result can never be dropped.
  assign start   = st_q == IDLE && ccnt_q != '0 && rcnt_q != (AW+1)'(DEPTH);
  always_comb begin
    st_d   = start ? ISSUE : c_pop ? WAIT : r_push ? IDLE : st_q;
    cwp_d  = cwp_q + AW'(c_push);
    crp_d  = crp_q + AW'(c_pop);
    rwp_d  = rwp_q + AW'(r_push);
    rrp_d  = rrp_q + AW'(r_pop);
    ccnt_d = ccnt_q + (AW+1)'(c_push) - (AW+1)'(c_pop);
    rcnt_d = rcnt_q + (AW+1)'(r_push) - (AW+1)'(r_pop);
    op_d   = start ? cmem[crp_q] : op_q;
    ovf_d  = ovf_q | (bus.cmd_wr & c_full);
    cnt_d  = cnt_q + CNT_WIDTH'(r_push);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)
      {st_q, cwp_q, crp_q, rwp_q, rrp_q, ccnt_q, rcnt_q, op_q, ovf_q, cnt_q} <= '0;
    else
      {st_q, cwp_q, crp_q, rwp_q, rrp_q, ccnt_q, rcnt_q, op_q, ovf_q, cnt_q} <= sw_rst ? '0 :
        {st_d, cwp_d, crp_d, rwp_d, rrp_d, ccnt_d, rcnt_d, op_d, ovf_d, cnt_d};
  always_ff @(posedge clk) begin
    if (c_push) cmem[cwp_q] <= {bus.cmd_1_re, bus.cmd_1_im, bus.cmd_2_re, bus.cmd_2_im};
    if (r_push) rmem[rwp_q] <= {bus.result_re, bus.result_im};
  end
  assign bus.cmd_full  = c_full;
  assign bus.ovf       = ovf_q;
  assign bus.op_val    = st_q == ISSUE;
  assign bus.res_ready = st_q == WAIT;
  assign {bus.op_1_re, bus.op_1_im, bus.op_2_re, bus.op_2_im} = op_q;
  assign {bus.rd_re, bus.rd_im} = r_empty ? '0 : rmem[rrp_q];
  assign bus.rd_empty  = r_empty;
  assign bus.done_cnt  = cnt_q;
endmodule

// File: tb/tb_complex_mult_master.sv
// tb_complex_mult_master: directed vectors against a behavioural three-cycle complex multiplier.
module tb_complex_mult_master;
  logic clk = 1'b0, rstn = 1'b0, sw_rst = 1'b0;
  logic rdy = 1'b0, res_en = 1'b1, man_val = 1'b0;
  logic pend = 1'b0;
  logic [1:0] dly = '0;
  logic [15:0] mre = '0, mim = '0, a16, b16, c16, d16;
  int tests = 0, fails = 0;
  typedef struct {logic [7:0] a, b, c, d; logic [15:0] re, im;} vec_t;
  vec_t vt[6];
  logic [15:0] exp_re[4], exp_im[4];
  complex_mult_master_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus();
  complex_mult_master #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .bus(bus)
  );
  always #5 clk = ~clk;
  assign a16 = {8'd0, bus.op_1_re};
  assign b16 = {8'd0, bus.op_1_im};
  assign c16 = {8'd0, bus.op_2_re};
  assign d16 = {8'd0, bus.op_2_im};
  assign bus.op_ready  = rdy;
  assign bus.res_val   = (pend && dly == 2'd0 && res_en) || man_val;
  assign bus.result_re = man_val ? 16'h1234 : mre;
  assign bus.result_im = man_val ? 16'h5678 : mim;
  always @(posedge clk)
    if (!rstn || sw_rst) pend <= 1'b0;
    else if (bus.op_val && bus.op_ready) begin
      pend <= 1'b1;
      dly  <= 2'd3;
      mre  <= a16 * c16 - b16 * d16;
      mim  <= a16 * d16 + b16 * c16;
    end else if (pend) begin
      if (dly != 2'd0) dly <= dly - 2'd1;
      else if (bus.res_val && bus.res_ready) pend <= 1'b0;
    end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [7:0] a, b, c, d);
    @(negedge clk);
    bus.cmd_wr = 1'b1;
    {bus.cmd_1_re, bus.cmd_1_im, bus.cmd_2_re, bus.cmd_2_im} = {a, b, c, d};
    @(negedge clk);
    bus.cmd_wr = 1'b0;
  endtask
  task automatic pop();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask
  task automatic wait_nonempty();
    for (int k = 0; k < 50 && bus.rd_empty; k++) @(negedge clk);
    chk("result_arrives", bus.rd_empty, 1'b0);
  endtask
  task automatic wait_done(input logic [15:0] n);
    for (int k = 0; k < 100 && bus.done_cnt != n; k++) @(negedge clk);
    chk("done_reached", bus.done_cnt, n);
  endtask
  initial begin
    vt[0] = '{8'd3,   8'd2,   8'd1,   8'd4,   16'hFFFB, 16'h000E};
    vt[1] = '{8'd1,   8'd0,   8'd1,   8'd0,   16'h0001, 16'h0000};
    vt[2] = '{8'd255, 8'd255, 8'd255, 8'd255, 16'h0000, 16'hFC02};
    vt[3] = '{8'd10,  8'd20,  8'd30,  8'd40,  16'hFE0C, 16'h03E8};
    vt[4] = '{8'd0,   8'd7,   8'd0,   8'd9,   16'hFFC1, 16'h0000};
    vt[5] = '{8'd128, 8'd1,   8'd2,   8'd128, 16'h0080, 16'h4002};
    exp_re = '{16'h0004, 16'h0009, 16'h0010, 16'h0018};
    exp_im = '{16'h0000, 16'h0000, 16'h0000, 16'h000A};
    bus.cmd_wr = 1'b0;
    bus.rd_en = 1'b0;
    {bus.cmd_1_re, bus.cmd_1_im, bus.cmd_2_re, bus.cmd_2_im} = '0;
    repeat (2) @(negedge clk);
    chk("rst_op_val", bus.op_val, 1'b0);
    chk("rst_res_ready", bus.res_ready, 1'b0);
    chk("rst_cmd_full", bus.cmd_full, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    chk("rst_rd_empty", bus.rd_empty, 1'b1);
    chk("rst_done_cnt", bus.done_cnt, 16'd0);
    chk("rst_op", {bus.op_1_re, bus.op_1_im, bus.op_2_re, bus.op_2_im}, 32'd0);
    chk("rst_rd", {bus.rd_re, bus.rd_im}, 32'd0);
    rstn = 1'b1;
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.cmd_wr = 1'b1;
      {bus.cmd_1_re, bus.cmd_1_im, bus.cmd_2_re, bus.cmd_2_im} = {vt[i].a, vt[i].b, vt[i].c, vt[i].d};
      @(negedge clk);
      bus.cmd_wr = 1'b0;
      chk("vec_op_val_early", bus.op_val, 1'b0);
      @(negedge clk);
      chk("vec_op_val", bus.op_val, 1'b1);
      chk("vec_operands", {bus.op_1_re, bus.op_1_im, bus.op_2_re, bus.op_2_im},
          {vt[i].a, vt[i].b, vt[i].c, vt[i].d});
      wait_nonempty();
      chk("vec_rd_re", bus.rd_re, vt[i].re);
      chk("vec_rd_im", bus.rd_im, vt[i].im);
      chk("vec_done_cnt", bus.done_cnt, 16'(i + 1));
      pop();
      chk("vec_empty_after_pop", bus.rd_empty, 1'b1);
    end
    // result backpressure: four stored results block the fifth operation
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.cmd_wr = 1'b1;
      {bus.cmd_1_re, bus.cmd_1_im, bus.cmd_2_re, bus.cmd_2_im} = {8'(i), 8'd0, 8'(i), 8'd0};
    end
    @(negedge clk);
    {bus.cmd_1_re, bus.cmd_1_im, bus.cmd_2_re, bus.cmd_2_im} = {8'd5, 8'd1, 8'd5, 8'd1};
    @(negedge clk);
    bus.cmd_wr = 1'b0;
    chk("bp_no_ovf", bus.ovf, 1'b0);
    wait_done(16'd10);
    repeat (10) @(negedge clk);
    chk("bp_done_held", bus.done_cnt, 16'd10);
    chk("bp_op_val_idle", bus.op_val, 1'b0);
    chk("bp_res_ready_idle", bus.res_ready, 1'b0);
    chk("bp_head", {bus.rd_re, bus.rd_im}, {16'h0001, 16'h0000});
    pop();
    chk("bp_next_head", bus.rd_re, 16'h0004);
    wait_done(16'd11);
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_re", bus.rd_re, exp_re[i]);
      chk("bp_drain_im", bus.rd_im, exp_im[i]);
      pop();
    end
    chk("bp_drained", bus.rd_empty, 1'b1);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("pop_empty_ignored", bus.rd_empty, 1'b1);
    // fill with the multiplier stalled
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        chk("fill_full", bus.cmd_full, 1'b1);
        chk("fill_ovf_before", bus.ovf, 1'b0);
      end
      bus.cmd_wr = 1'b1;
      case (i)
        0: {bus.cmd_1_re, bus.cmd_1_im, bus.cmd_2_re, bus.cmd_2_im} = {8'd1, 8'd2, 8'd3, 8'd4};
        1: {bus.cmd_1_re, bus.cmd_1_im, bus.cmd_2_re, bus.cmd_2_im} = {8'd2, 8'd3, 8'd4, 8'd5};
        2: {bus.cmd_1_re, bus.cmd_1_im, bus.cmd_2_re, bus.cmd_2_im} = {8'd5, 8'd0, 8'd5, 8'd0};
        3: {bus.cmd_1_re, bus.cmd_1_im, bus.cmd_2_re, bus.cmd_2_im} = {8'd6, 8'd0, 8'd6, 8'd0};
        default: {bus.cmd_1_re, bus.cmd_1_im, bus.cmd_2_re, bus.cmd_2_im} = {8'd9, 8'd9, 8'd9, 8'd9};
      endcase
    end
    @(negedge clk);
    bus.cmd_wr = 1'b0;
    chk("fill_ovf", bus.ovf, 1'b1);
    chk("fill_full_after", bus.cmd_full, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", {bus.op_val, bus.op_1_re, bus.op_1_im, bus.op_2_re, bus.op_2_im},
          {1'b1, 8'd1, 8'd2, 8'd3, 8'd4});
    end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    chk("stall_one_pop", bus.cmd_full, 1'b0);
    chk("stall_op_val_drop", bus.op_val, 1'b0);
    chk("stall_res_ready", bus.res_ready, 1'b1);
    wait_nonempty();
    chk("stall_result", {bus.rd_re, bus.rd_im}, {16'hFFFB, 16'h000A});
    chk("stall_done", bus.done_cnt, 16'd12);
    repeat (2) @(negedge clk);
    chk("next_issue", {bus.op_val, bus.op_1_re}, {1'b1, 8'd2});
    rdy = 1'b1;
    wait_done(16'd13);
    res_en = 1'b0;
    repeat (6) @(negedge clk);
    rdy = 1'b0;
    chk("wait_res_ready", bus.res_ready, 1'b1);
    chk("wait_head", {bus.rd_re, bus.rd_im}, {16'hFFFB, 16'h000A});
    chk("wait_ovf", bus.ovf, 1'b1);
    // software reset in the middle of an operation
    sw_rst = 1'b1;
    @(negedge clk);
    sw_rst = 1'b0;
    res_en = 1'b1;
    chk("sw_rd_empty", bus.rd_empty, 1'b1);
    chk("sw_cmd_full", bus.cmd_full, 1'b0);
    chk("sw_op_val", bus.op_val, 1'b0);
    chk("sw_res_ready", bus.res_ready, 1'b0);
    chk("sw_done", bus.done_cnt, 16'd0);
    chk("sw_ovf", bus.ovf, 1'b0);
    man_val = 1'b1;
    repeat (5) @(negedge clk);
    man_val = 1'b0;
    chk("stray_res_empty", bus.rd_empty, 1'b1);
    chk("stray_res_done", bus.done_cnt, 16'd0);
    chk("stray_op_val", bus.op_val, 1'b0);
    // asynchronous reset between edges while issuing
    wr(8'd7, 8'd1, 8'd2, 8'd3);
    @(negedge clk);
    chk("arst_pre_issue", bus.op_val, 1'b1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_op_val", bus.op_val, 1'b0);
    chk("arst_op", {bus.op_1_re, bus.op_1_im, bus.op_2_re, bus.op_2_im}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    rdy = 1'b1;
    wr(8'd2, 8'd1, 8'd3, 8'd1);
    wait_nonempty();
    chk("arst_result", {bus.rd_re, bus.rd_im}, {16'h0005, 16'h0005});
    chk("arst_done", bus.done_cnt, 16'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/complex_mult_master.md
Name: complex_mult_master

Overview:
- Initiator-side companion to the single-multiplier complex number unit: the other end of its op_val/op_ready operand handshake and its res_val/res_ready result handshake.
- Buffers operand sets written by a host in an operand FIFO and issues them one at a time to the multiplier.
- Collects each result into a result FIFO that the host reads.
- Exactly one operation in flight, because the multiplier is single-instance and sequential.

Parameters:
DATA_WIDTH, 8, width of each operand component; results are 2*DATA_WIDTH.
DEPTH, 4, entries in each of the operand and result FIFOs; power of 2, >= 2.
CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  asynchronous reset, active low
sw_rst  input  1  synchronous software reset, active high
cmd_wr  input  1  host writes one operand set this cycle
cmd_1_re, cmd_1_im, cmd_2_re, cmd_2_im  input  DATA_WIDTH each  operand set components
cmd_full  output  1  operand FIFO full
ovf  output  1  sticky: cmd_wr dropped while full
op_val  output  1  operand set valid toward multiplier
op_ready  input  1  multiplier accepts operands
op_1_re, op_1_im, op_2_re, op_2_im  output  DATA_WIDTH each  operands toward multiplier
res_val  input  1  multiplier result valid
res_ready  output  1  this block accepts a result
result_re, result_im  input  2*DATA_WIDTH each  result from multiplier
rd_en  input  1  host pops one result
rd_re, rd_im  output  2*DATA_WIDTH each  head of result FIFO (show-ahead)
rd_empty  output  1  result FIFO empty
done_cnt  output  CNT_WIDTH  completed operations, wraps to 0

Behaviour:
- Reset (rstn=0, async): both FIFOs empty, state IDLE, op_val=0, res_ready=0, cmd_full=0, ovf=0, rd_empty=1, done_cnt=0, op_*=0, rd_re=rd_im=0.
- sw_rst=1 at a clock edge has the same effect synchronously and overrides all other inputs that cycle. This includes mid-operation: the in-flight operation is abandoned and the result FIFO is flushed.
- Transfers: an operand transfer happens at an edge where op_val&&op_ready. A result transfer happens at an edge where res_val&&res_ready.
- Operand FIFO: cmd_wr with !cmd_full pushes {cmd_1_re, cmd_1_im, cmd_2_re, cmd_2_im}. cmd_wr while full is dropped and sets ovf; ovf clears only on reset/sw_rst.
- Simultaneous push and pop when full: the pop frees a slot, but cmd_full is sampled before the edge, so the write is still dropped.
- FSM:
  - IDLE: go to ISSUE when the operand FIFO is non-empty AND result FIFO occupancy < DEPTH. This reserves space, so results are never dropped.
  - ISSUE: op_val=1 with the operand FIFO head driven on op_*, held stable until the transfer. On transfer, pop the operand FIFO, drop op_val, go to WAIT.
  - WAIT: res_ready=1. On transfer, push {result_re, result_im}, increment done_cnt, go to IDLE.
- op_val and res_ready are registered and decoded from state only; they never depend combinationally on op_ready/res_val.
- op_* outputs hold their last values outside ISSUE.
- Latency: a cmd_wr at edge N into an empty FIFO with the FSM in IDLE gives op_val=1 after edge N+1. If op_ready is already high, the transfer happens at edge N+2.
- Back-to-back throughput: minimum 3 cycles per operation (IDLE, ISSUE, WAIT), plus multiplier latency.
- Result FIFO: rd_re/rd_im show the head whenever !rd_empty. rd_en with !rd_empty pops. rd_en while empty is ignored. A push and pop in the same cycle are both performed.
- FIFO pointers wrap modulo DEPTH. Occupancy counts span 0..DEPTH.
- done_cnt wraps from 2^CNT_WIDTH-1 to 0.
- res_val received outside WAIT is ignored; res_ready is 0 there.

Test Plan:
1. Single op: reset, write (3,2,1,4); the bench multiplier returns re=a*c-b*d, im=a*d+b*c mod 2^16 three cycles after accept.
   -> op_val high 1 cycle after the write; rd_empty falls with rd_re=16'hFFFB, rd_im=16'h000E; done_cnt=1.
2. Fill: 5 writes back-to-back with op_ready=0, DEPTH=4.
   -> One entry moves to ISSUE; after the 4 buffered entries cmd_full=1; the 5th write is dropped and ovf=1.
3. Result backpressure: issue 5 ops, never assert rd_en.
   -> Exactly 4 results are stored; FSM stays in IDLE with op_val=0 while the operand FIFO holds the 5th.
   -> One rd_en pops (1,0,1,0)'s result 16'h0001; the 5th op then issues.
4. Stalled handshake: hold op_ready=0 for 10 cycles during ISSUE.
   -> op_val stays 1 and op_* stay constant; on op_ready=1, exactly one pop occurs.
5. sw_rst pulse while in WAIT with 2 results stored.
   -> Next cycle: rd_empty=1, cmd_full=0, op_val=0, res_ready=0, done_cnt=0, ovf=0.
   -> A later res_val=1 is ignored.
6. rstn asserted low mid-ISSUE, asynchronously between edges.
   -> op_val drops immediately; after release, a new write issues normally.
